display_port: RTL and testbench
===============================

# display_port

Display-side port of the Apple-1 core. It accepts character writes from the 6502 on `cpu_clken`-qualified bus cycles and buffers them in a small FIFO. It reports a busy flag back to the CPU in bit 7 of the DSP register, and presents characters one at a time to the video terminal over a valid/ready handshake, with optional pacing. It sits directly downstream of the clock-enable divider and shares its `clk7` domain.

## Interface
Parameters:
- `DEPTH`, 4: FIFO depth in characters. Must be a power of two, ≥2.
- `PACE_TICKS`, 0: number of `cpu_clken` ticks to wait after each accepted character before presenting the next. 0 means no pacing.

Ports:
- `clk7`  in  1  7 MHz master clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_clken`  in  1  1 MHz CPU clock enable from the divider.
- `dsp_cs`  in  1  CPU addresses the DSP register ($D012).
- `cpu_we`  in  1  CPU write strobe, valid when `dsp_cs`.
- `cpu_din`  in  8  CPU write data. Bit 7 is ignored.
- `dsp_dout`  out  8  read data: {busy, last_char[6:0]}.
- `term_valid`  out  1  character available to the terminal.
- `term_char`  out  7  character to the terminal.
- `term_ready`  in  1  terminal accepts `term_char`.
- `overflow`  out  1  sticky: a write was dropped because the FIFO was full.

## Operation
- **Push.** A push occurs on a `clk7` edge with `cpu_clken & dsp_cs & cpu_we`. It stores `cpu_din[6:0]` and also loads `last_char`.
- **Push when full.** The write is dropped and `overflow` is set. Exception: if a pop happens in the same cycle, the push is accepted and the count is unchanged.
- **Pop.** A pop occurs on the cycle in which the output FSM loads a character from the FIFO head.
- **busy.** `busy` = FIFO count == `DEPTH`. `dsp_dout` is combinational from registers.
- **FSM states:**
  - IDLE: `term_valid`=0. Moves to SHOW when the FIFO is not empty; the head is popped into the `term_char` register in the same cycle.
  - SHOW: `term_valid`=1 and `term_char` is held stable. On `term_ready`:
    - go to PACE if `PACE_TICKS`>0;
    - otherwise go to IDLE, or reload directly and stay in SHOW if the FIFO is not empty.
  - PACE: `term_valid`=0. The pace counter decrements on each `cpu_clken`. On reaching 0, go to IDLE.
- **Widths.**
  - FIFO pointers: log2(`DEPTH`) bits, wrapping modulo `DEPTH`.
  - Count: log2(`DEPTH`)+1 bits.
  - Pace counter: wide enough for `PACE_TICKS`.
- **Reset** (async, any time, including mid-handshake):
  - FIFO empties and pointers go to 0.
  - FSM goes to IDLE.
  - `term_valid`=0, `term_char`=0, `last_char`=0, `overflow`=0, so `dsp_dout`=0x00.

## Timing
- Write to `busy`: a push on edge N updates `busy` after edge N, so it is visible on the next `cpu_clken` read.
- Write to terminal, FIFO empty and FSM in IDLE: push on edge N, pop/load on edge N+1, `term_valid`=1 after edge N+1. Latency is 2 `clk7` edges.
- Handshake: the transfer completes on an edge where `term_valid & term_ready`. `term_char` must not change while `term_valid`=1 and `term_ready`=0.
- Back-to-back transfers with `PACE_TICKS`=0: one character per `clk7` cycle while `term_ready` is held high.
- With pacing: the next `term_valid` rises no earlier than `PACE_TICKS` `cpu_clken` pulses (plus one IDLE cycle) after the accepting edge.
- `cpu_clken` gates only pushes and pacing. Pops and the handshake run at the full `clk7` rate.

## Structure
- Shared package `apple1_pkg`: `CHAR_W`=7 and the DSP busy-bit index constant (7).
- Sub-module `char_fifo`: synchronous FIFO parameterised by `DEPTH` and `CHAR_W`, with push, pop, full, empty and count, and async reset.
- The FSM, pace counter, `last_char`, `overflow` and the bus decode stay in `display_port`.

## Test plan
- **Reset.** Assert `reset` mid-SHOW with 2 characters queued → immediately `term_valid`=0, `dsp_dout`=0x00, `overflow`=0. After release, no characters are emitted.
- **Single write.** `PACE_TICKS`=0, `term_ready`=1, write 0xC1 → `term_char`=0x41 with `term_valid` high for 1 cycle, 2 edges after the push. `dsp_dout`=0x41.
- **Fill.** `term_ready`=0, write 0x41–0x45 with `DEPTH`=4 → first character in SHOW and 4 buffered, `busy`=1. The 6th write is dropped and `overflow`=1. Releasing ready yields exactly 0x41..0x45 in order.
- **Simultaneous push/pop when full.** Hold the FIFO full, then write in the same cycle as a pop → write accepted, `overflow` stays 0, and the order is preserved.
- **Pacing.** `PACE_TICKS`=3, queue 2 characters → the gap between the first accept and the second `term_valid` rise is ≥3 `cpu_clken` pulses.
- **Backpressure.** Toggle `term_ready` randomly → `term_char` is stable while `term_valid & !term_ready`, and no character is lost or duplicated across 64 writes with wrap-around.

Source files
------------

// File: rtl/apple1_pkg.sv
// Constants and types shared across the Apple-1 core blocks.
package apple1_pkg;

  localparam int CHAR_W       = 7;
  localparam int DSP_BUSY_BIT = 7;

  typedef enum logic [1:0] {
    DSP_IDLE,
    DSP_SHOW,
    DSP_PACE
  } dsp_state_e;

endpackage

// File: rtl/char_fifo.sv
// Small synchronous character FIFO with occupancy count; a push into a full
// FIFO is accepted only when a pop frees the head slot on the same edge.
module char_fifo #(
  parameter int DEPTH  = 4,
  parameter int CHAR_W = 7
) (
  input  logic                     clk7,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [CHAR_W-1:0]        din,
  output logic [CHAR_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [CHAR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // When full, wr_ptr equals rd_ptr: the old head is read before this write lands.
  always_ff @(posedge clk7) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk7 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/display_port.sv
// Apple-1 display port: buffers CPU writes to $D012 and hands characters to
// the video terminal over valid/ready, with optional cpu_clken-based pacing.
module display_port
  import apple1_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int PACE_TICKS = 0
) (
  input  logic              clk7,
  input  logic              reset,
  input  logic              cpu_clken,
  input  logic              dsp_cs,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        dsp_dout,
  output logic              term_valid,
  output logic [CHAR_W-1:0] term_char,
  input  logic              term_ready,
  output logic              overflow
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int PACE_W = (PACE_TICKS > 0) ? $clog2(PACE_TICKS + 1) : 1;

  dsp_state_e        state;
  dsp_state_e        state_next;
  logic              push;
  logic              pop;
  logic              load_pace;
  logic              fifo_full;
  logic              fifo_empty;
  logic              busy;
  logic [CNT_W-1:0]  fifo_count;
  logic [CHAR_W-1:0] fifo_head;
  logic [CHAR_W-1:0] last_char;
  logic [PACE_W-1:0] pace_cnt;
  logic              unused_din_msb;

  assign unused_din_msb = cpu_din[7];
  assign push           = cpu_clken & dsp_cs & cpu_we;

  char_fifo #(
    .DEPTH  (DEPTH),
    .CHAR_W (CHAR_W)
  ) u_fifo (
    .clk7  (clk7),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (cpu_din[CHAR_W-1:0]),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk7 or posedge reset) begin
    if (reset) state <= DSP_IDLE;
    else       state <= state_next;
  end

  // With pacing off, SHOW reloads straight from the FIFO for one char per cycle.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_pace  = 1'b0;
    case (state)
      DSP_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = DSP_SHOW;
        end
      end
      DSP_SHOW: begin
        if (term_ready) begin
          if (PACE_TICKS > 0) begin
            load_pace  = 1'b1;
            state_next = DSP_PACE;
          end else if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_next = DSP_IDLE;
          end
        end
      end
      DSP_PACE: begin
        if (cpu_clken && pace_cnt == PACE_W'(1)) state_next = DSP_IDLE;
      end
      default: state_next = DSP_IDLE;
    endcase
  end

  always_ff @(posedge clk7 or posedge reset) begin
    if (reset) begin
      pace_cnt <= '0;
    end else if (load_pace) begin
      pace_cnt <= PACE_W'(PACE_TICKS);
    end else if (state == DSP_PACE && cpu_clken && pace_cnt != '0) begin
      pace_cnt <= pace_cnt - 1'b1;
    end
  end

  // A dropped write still updates last_char; only the FIFO store is lost.
  always_ff @(posedge clk7 or posedge reset) begin
    if (reset) begin
      term_char <= '0;
      last_char <= '0;
      overflow  <= 1'b0;
    end else begin
      if (pop)  term_char <= fifo_head;
      if (push) last_char <= cpu_din[CHAR_W-1:0];
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  assign term_valid = (state == DSP_SHOW);
  assign busy       = (fifo_count == CNT_W'(DEPTH));

  always_comb begin
    dsp_dout               = '0;
    dsp_dout[CHAR_W-1:0]   = last_char;
    dsp_dout[DSP_BUSY_BIT] = busy;
  end

endmodule

// File: tb/tb_display_port.sv
// Scoreboard bench for display_port: one unpaced instance for the data path,
// one instance with PACE_TICKS=3 for the pacing gap.
module tb_display_port;

  logic       clk7 = 1'b0;
  logic       reset;
  logic       cpu_clken;
  logic       dsp_cs, cpu_we, term_ready;
  logic [7:0] cpu_din;
  logic [7:0] dsp_dout;
  logic       term_valid, overflow;
  logic [6:0] term_char;

  logic       p_dsp_cs, p_cpu_we, p_term_ready;
  logic [7:0] p_cpu_din;
  logic [7:0] p_dsp_dout;
  logic       p_term_valid, p_overflow;
  logic [6:0] p_term_char;

  int total = 0;
  int bad   = 0;
  logic [6:0] exp_q[$];
  logic [6:0] p_q[$];
  bit   bp_done;
  int   p_rcv = 0;
  int   p_gap_seen = 0;

  display_port #(.DEPTH(4), .PACE_TICKS(0)) dut (
    .clk7(clk7), .reset(reset), .cpu_clken(cpu_clken), .dsp_cs(dsp_cs),
    .cpu_we(cpu_we), .cpu_din(cpu_din), .dsp_dout(dsp_dout),
    .term_valid(term_valid), .term_char(term_char), .term_ready(term_ready),
    .overflow(overflow)
  );

  display_port #(.DEPTH(4), .PACE_TICKS(3)) dut_pace (
    .clk7(clk7), .reset(reset), .cpu_clken(cpu_clken), .dsp_cs(p_dsp_cs),
    .cpu_we(p_cpu_we), .cpu_din(p_cpu_din), .dsp_dout(p_dsp_dout),
    .term_valid(p_term_valid), .term_char(p_term_char), .term_ready(p_term_ready),
    .overflow(p_overflow)
  );

  initial forever #5 clk7 = ~clk7;

  // 1-in-7 clock enable, changing on the falling edge
  initial begin
    forever begin
      cpu_clken = 1'b0;
      repeat (6) @(negedge clk7);
      cpu_clken = 1'b1;
      @(negedge clk7);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit pace_dut, input logic [7:0] d, input bit expect_out);
    if (!pace_dut) begin
      if (expect_out) exp_q.push_back(d[6:0]);
      dsp_cs = 1'b1; cpu_we = 1'b1; cpu_din = d;
    end else begin
      if (expect_out) p_q.push_back(d[6:0]);
      p_dsp_cs = 1'b1; p_cpu_we = 1'b1; p_cpu_din = d;
    end
    do @(posedge clk7); while (!cpu_clken);
    #1;
    dsp_cs = 1'b0; cpu_we = 1'b0; p_dsp_cs = 1'b0; p_cpu_we = 1'b0;
  endtask

  // Lands a write on the same edge as a SHOW->SHOW reload of the full FIFO
  task automatic syncPushPop(input logic [7:0] d);
    exp_q.push_back(d[6:0]);
    do @(posedge clk7); while (!cpu_clken);
    repeat (6) @(posedge clk7);
    #1;
    term_ready = 1'b1; dsp_cs = 1'b1; cpu_we = 1'b1; cpu_din = d;
    @(posedge clk7);
    #1;
    term_ready = 1'b0; dsp_cs = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 300 && (exp_q.size() != 0 || term_valid); i++) @(posedge clk7);
    #1;
    checkOutput(name, exp_q.size(), 0);
  endtask

  // Scoreboard monitor for the unpaced instance
  initial begin
    bit         stall_prev = 1'b0;
    logic [6:0] held_char  = '0;
    logic [6:0] exp;
    forever begin
      @(negedge clk7);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checkOutput("hold_valid", int'(term_valid), 1);
          checkOutput("hold_char", int'(term_char), int'(held_char));
        end
        if (term_valid && term_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_char actual=0x%0h required=none", term_char);
          end else begin
            exp = exp_q.pop_front();
            checkOutput("term_char", int'(term_char), int'(exp));
          end
        end
        stall_prev = term_valid && !term_ready;
        held_char  = term_char;
      end
    end
  end

  // Paced instance: order plus cpu_clken pulses between accept and next valid
  initial begin
    bit         prev_valid = 1'b0;
    bit         waiting    = 1'b0;
    bit         skip       = 1'b0;
    int         pulses     = 0;
    logic [6:0] exp;
    forever begin
      @(posedge clk7);
      if (waiting) begin
        if (skip) skip = 1'b0;
        else if (cpu_clken) pulses++;
      end
      @(negedge clk7);
      if (!reset) begin
        if (p_term_valid && !prev_valid && waiting) begin
          checkOutput("pace_gap_ge3", int'(pulses >= 3), 1);
          p_gap_seen++;
          waiting = 1'b0;
        end
        if (p_term_valid && p_term_ready) begin
          if (p_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL pace_unexpected actual=0x%0h required=none", p_term_char);
          end else begin
            exp = p_q.pop_front();
            checkOutput("pace_char", int'(p_term_char), int'(exp));
          end
          p_rcv++;
          waiting = 1'b1;
          skip    = 1'b1;
          pulses  = 0;
        end
        prev_valid = p_term_valid;
      end
    end
  end

  initial begin
    reset = 1'b1;
    dsp_cs = 1'b0; cpu_we = 1'b0; cpu_din = '0; term_ready = 1'b0;
    p_dsp_cs = 1'b0; p_cpu_we = 1'b0; p_cpu_din = '0; p_term_ready = 1'b0;
    repeat (3) @(posedge clk7);
    #1;
    checkOutput("rst_dout", int'(dsp_dout), 8'h00);
    checkOutput("rst_valid", int'(term_valid), 0);
    checkOutput("rst_char", int'(term_char), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk7);
    #1;

    $display("[TB] single write");
    term_ready = 1'b1;
    applyStimulus(0, 8'hC1, 1);
    checkOutput("single_valid_n", int'(term_valid), 0);
    checkOutput("single_dout", int'(dsp_dout), 8'h41);
    @(posedge clk7); #1;
    checkOutput("single_valid_n1", int'(term_valid), 1);
    checkOutput("single_char", int'(term_char), 8'h41);
    @(posedge clk7); #1;
    checkOutput("single_valid_n2", int'(term_valid), 0);

    $display("[TB] fill and overflow");
    term_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(0, 8'(8'h41 + i), 1);
    checkOutput("fill_busy_dout", int'(dsp_dout), 8'hC5);
    checkOutput("fill_overflow_pre", int'(overflow), 0);
    applyStimulus(0, 8'h46, 0);
    checkOutput("fill_overflow", int'(overflow), 1);
    checkOutput("fill_busy_bit", int'(dsp_dout[7]), 1);
    term_ready = 1'b1;
    waitDrain("fill_drain");

    $display("[TB] reset mid-show");
    term_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'(8'h60 + i), 1);
    checkOutput("mid_valid_pre", int'(term_valid), 1);
    checkOutput("mid_overflow_pre", int'(overflow), 1);
    @(posedge clk7); #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("mid_rst_valid", int'(term_valid), 0);
    checkOutput("mid_rst_dout", int'(dsp_dout), 8'h00);
    checkOutput("mid_rst_overflow", int'(overflow), 0);
    repeat (3) @(posedge clk7);
    #1;
    reset = 1'b0;
    term_ready = 1'b1;
    repeat (20) @(posedge clk7);
    #1;
    checkOutput("post_rst_valid", int'(term_valid), 0);
    checkOutput("post_rst_dout", int'(dsp_dout), 8'h00);

    $display("[TB] push and pop on the same edge while full");
    term_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(0, 8'(8'h50 + i), 1);
    checkOutput("sim_full_dout", int'(dsp_dout), 8'hD4);
    syncPushPop(8'h55);
    checkOutput("sim_overflow", int'(overflow), 0);
    checkOutput("sim_dout", int'(dsp_dout), 8'hD5);
    term_ready = 1'b1;
    waitDrain("sim_drain");

    $display("[TB] backpressure");
    bp_done = 1'b0;
    fork
      begin
        while (!bp_done) begin
          @(posedge clk7);
          #1;
          term_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 64; i++) applyStimulus(0, {i[0], 7'(i * 5 + 3)}, 1);
    bp_done = 1'b1;
    @(posedge clk7);
    #2;
    term_ready = 1'b1;
    waitDrain("bp_drain");
    checkOutput("bp_overflow", int'(overflow), 0);

    $display("[TB] pacing");
    p_term_ready = 1'b1;
    applyStimulus(1, 8'h70, 1);
    applyStimulus(1, 8'h71, 1);
    for (int i = 0; i < 300 && p_rcv < 2; i++) @(posedge clk7);
    #1;
    checkOutput("pace_count", p_rcv, 2);
    checkOutput("pace_gap_checked", p_gap_seen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
